// File: rtl/buffer.sv
// Single-slot guess buffer between a UART-style receiver and the game logic.
// Captures a byte on each rising edge of ready and hands it to guess when game_rdy allows.
module buffer (
  input  logic       clk,
  input  logic       nRst,
  input  logic       ready,
  input  logic [7:0] Rx_byte,
  input  logic       game_rdy,
  output logic [7:0] guess
);

  logic       ready_q;
  logic [7:0] hold;
  logic       valid;

  logic       capture;
  logic       transfer;
  logic       valid_next;

  // A level held high on ready captures only once.
  assign capture  = ready & ~ready_q;
  assign transfer = game_rdy & valid;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    valid_next = valid;
    if (capture) begin
      valid_next = 1'b1;
    end else if (transfer) begin
      valid_next = 1'b0;
    end
  end

  // A simultaneous capture and transfer sends the old hold to guess while hold takes the new byte.
  always_ff @(posedge clk) begin
    if (nRst) begin
      // NOTE: the data registers are reset as well, so a byte buffered before reset can never leak out.
      ready_q <= 1'b0;
      hold    <= 8'h00;
      valid   <= 1'b0;
      guess   <= 8'h00;
    end else begin
      // NOTE: non-blocking assignments let guess read the pre-edge value of hold within this edge.
      ready_q <= ready;
      valid   <= valid_next;
      if (capture) begin
        hold <= Rx_byte;
      end
      if (transfer) begin
        guess <= hold;
      end
    end
  end

endmodule

// File: tb/tb_buffer.sv
// Randomized scoreboard bench for buffer: the stimulus side pushes the expected guess per clock edge,
// and an independent monitor pops and compares shortly after each edge.
module tb_buffer;

  logic       tb_clk;
  logic       nRst;
  logic       ready;
  logic [7:0] Rx_byte;
  logic       game_rdy;
  logic [7:0] guess;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  string      tag_q[$];

  // Reference model: the newest unreceived byte sits in a one-deep list of pending bytes.
  logic       m_prev_ready;
  logic [7:0] m_pending[$];
  logic [7:0] m_guess;

  buffer dut (
    .clk      (tb_clk),
    .nRst     (nRst),
    .ready    (ready),
    .Rx_byte  (Rx_byte),
    .game_rdy (game_rdy),
    .guess    (guess)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: guess=%02h expected=%02h at %0t", name, actual, expected, $time);
    end
  endtask

  // Applies the receiver/game rules to one clock edge, then queues the guess expected after it.
  task automatic step(input string name, input logic r, input logic rd, input logic [7:0] rx,
                      input logic g);
    logic new_byte;
    @(negedge tb_clk);
    nRst     = r;
    ready    = rd;
    Rx_byte  = rx;
    game_rdy = g;
    if (r) begin
      m_prev_ready = 1'b0;
      m_pending.delete();
      m_guess = 8'h00;
    end else begin
      new_byte = rd && !m_prev_ready;
      if (g && m_pending.size() > 0) begin
        m_guess = m_pending.pop_front();
      end
      if (new_byte) begin
        m_pending.delete();
        m_pending.push_back(rx);
      end
      m_prev_ready = rd;
    end
    @(posedge tb_clk);
    exp_q.push_back(m_guess);
    tag_q.push_back(name);
  endtask

  // Monitor: guess is a registered output, so one comparison per edge, sampled 1 time unit later.
  initial begin
    forever begin
      @(posedge tb_clk);
      #1;
      if (exp_q.size() > 0) begin
        check(tag_q.pop_front(), guess, exp_q.pop_front());
      end
    end
  end

  initial begin
    nRst = 1'b1; ready = 1'b0; Rx_byte = 8'h00; game_rdy = 1'b0;
    m_prev_ready = 1'b0; m_guess = 8'h00;

    // Reset with junk on Rx_byte.
    step("reset0", 1'b1, 1'b0, 8'd5, 1'b0);
    step("reset1", 1'b1, 1'b0, 8'd5, 1'b0);

    // Held ready captures once; guess stays 0 while game_rdy is low.
    for (int i = 0; i < 5; i++) step("ready_hold", 1'b0, 1'b1, 8'd5, 1'b0);
    // Release ready and let the game take the byte.
    for (int i = 0; i < 4; i++) step("transfer", 1'b0, 1'b0, 8'd5, 1'b1);

    // Both rising straight out of reset.
    step("rst_both", 1'b1, 1'b0, 8'd0, 1'b0);
    for (int i = 0; i < 4; i++) step("both_rise", 1'b0, 1'b1, 8'd5, 1'b1);

    // Overwrite: 0x41 then 0x42 with game_rdy low, then transfer.
    step("ow_gap0", 1'b0, 1'b0, 8'h00, 1'b0);
    step("ow_cap41", 1'b0, 1'b1, 8'h41, 1'b0);
    step("ow_gap1", 1'b0, 1'b0, 8'h99, 1'b0);
    step("ow_cap42", 1'b0, 1'b1, 8'h42, 1'b0);
    step("ow_gap2", 1'b0, 1'b0, 8'h77, 1'b0);
    for (int i = 0; i < 3; i++) step("ow_xfer", 1'b0, 1'b0, 8'h00, 1'b1);

    // Simultaneous capture and transfer keeps the new byte pending.
    step("sim_cap", 1'b0, 1'b1, 8'h10, 1'b0);
    step("sim_gap", 1'b0, 1'b0, 8'h00, 1'b0);
    step("sim_both", 1'b0, 1'b1, 8'h20, 1'b1);
    step("sim_next", 1'b0, 1'b0, 8'h00, 1'b1);
    step("sim_idle", 1'b0, 1'b0, 8'h00, 1'b1);

    // Reset discards a pending byte; a later one-cycle pulse delivers two edges on.
    step("rd_gap", 1'b0, 1'b0, 8'h00, 1'b0);
    step("rd_cap", 1'b0, 1'b1, 8'h5a, 1'b0);
    step("rd_low", 1'b0, 1'b0, 8'h00, 1'b0);
    step("rd_rst", 1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) step("rd_after", 1'b0, 1'b0, 8'h00, 1'b1);
    step("rd_pulse", 1'b0, 1'b1, 8'h6b, 1'b1);
    for (int i = 0; i < 3; i++) step("rd_deliver", 1'b0, 1'b0, 8'h00, 1'b1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step("random", ($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0),
           8'($urandom), ($urandom_range(0, 3) != 0));
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge tb_clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/buffer.md
BUFFER -- requirements
Module: buffer

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports named clk and nRst.
REQ-002 Port: clk  input  1  system clock; all state updates on its rising edge.
REQ-003 Port: nRst  input  1  synchronous reset; asserted when 1, sampled on rising clk; no asynchronous path.
REQ-004 Port: ready  input  1  receiver strobe/level; high while Rx_byte carries a newly received byte.
REQ-005 Port: Rx_byte  input  8  received data byte (ASCII guess character).
REQ-006 Port: game_rdy  input  1  game logic able to accept a guess.
REQ-007 Port: guess  output  8  registered guess byte delivered to game logic.
REQ-008 There SHALL be no parameters; all widths are fixed at 8 bits.

Function
REQ-009 Internal state SHALL be exactly: ready_q (1b, previous ready), hold (8b, buffered byte), valid (1b, hold occupied), guess register (8b).
REQ-010 ready_q SHALL load ready every non-reset cycle.
REQ-011 A capture event SHALL be ready==1 && ready_q==0 (rising edge), so a level held high captures once only.
REQ-012 On a capture event, hold SHALL load Rx_byte and valid SHALL be set, on that same clock edge.
REQ-013 A capture while valid==1 SHALL overwrite hold with the new byte (newest byte wins); no overflow flag exists.
REQ-014 A transfer event SHALL be game_rdy==1 && valid==1 at a rising edge.
REQ-015 On a transfer event, guess SHALL load hold and valid SHALL clear on that edge, unless a capture also occurs (REQ-017).
REQ-016 Transfer latency: byte captured at edge N SHALL appear on guess at the edge following N (edge N+1) if game_rdy is high then; there is no combinational Rx_byte-to-guess bypass.
REQ-017 Simultaneous capture and transfer: guess SHALL take the old hold value, hold SHALL take the new Rx_byte, and valid SHALL remain 1.
REQ-018 With valid==0, game_rdy SHALL have no effect; guess SHALL hold its value.
REQ-019 With game_rdy==0, a captured byte SHALL stay in hold indefinitely and guess SHALL hold its value.
REQ-020 guess SHALL change only on a transfer event or reset; it SHALL never go to X or glitch between edges.
REQ-021 Rx_byte SHALL be ignored on all cycles without a capture event.

Reset
REQ-022 When nRst==1 at a rising edge, guess=8'h00, hold=8'h00, valid=0, ready_q=0, overriding all capture/transfer activity that cycle.
REQ-023 Reset asserted mid-operation SHALL discard any buffered byte; a byte pending in hold SHALL NOT be delivered after reset.
REQ-024 On the first edge after reset release, a ready already high SHALL count as a rising edge (ready_q==0) and capture.

Verification
REQ-025 Reset: Rx_byte=5, ready=0, game_rdy=0, nRst pulsed 2 cycles -> guess=0, valid=0 after the first reset edge.
REQ-026 ready=1 held 5 cycles, game_rdy=0, Rx_byte=5 -> single capture (hold=5, valid=1), guess stays 0.
REQ-027 Then ready=0, game_rdy=1 -> guess=5 one edge after game_rdy rises; valid clears; guess stays 5.
REQ-028 ready and game_rdy both rising together from reset, Rx_byte=5 -> capture at edge N, guess=5 at edge N+1, no further captures while ready stays high.
REQ-029 Capture Rx_byte=8'h41, then Rx_byte=8'h42 with game_rdy=0 -> later transfer gives guess=8'h42 (overwrite).
REQ-030 Capture a byte, assert nRst one cycle before game_rdy, then game_rdy=1 -> guess remains 0 until a new ready pulse; a ready pulse of one cycle with game_rdy=1 -> guess=Rx_byte two edges after the pulse.
